main_mem_port: RTL

Single-ported main-memory front end that sits directly downstream of the memory execution element. It accepts that element's write channel (`main_mem_in_*`) and read channel (`main_mem_out_*`) valid/ready requests and arbitrates them onto one synchronous SRAM port with fixed read latency. It returns exactly one single-cycle `ready` pulse per request. An optional one-entry write buffer acknowledges stores early and forwards store data to matching loads.

---
 rtl/main_mem_port.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/main_mem_port.sv
// Single-ported main-memory front end: arbitrates store and load requests onto one synchronous SRAM port.
// Define MAIN_MEM_PORT_WBUF_EN to add a one-entry write buffer with store-to-load forwarding.
module main_mem_port #(
   parameter int ADDR_WIDTH   = 20,
   parameter int READ_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           in_addr,
   input  logic [31:0]           in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           out_addr,
   input  logic                  out_valid,
   output logic [31:0]           out_data,
   output logic                  out_ready,
   output logic                  sram_en,
   output logic                  sram_we,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [31:0]           sram_wdata,
   input  logic [31:0]           sram_rdata
);

   localparam int CNT_W = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);

`ifdef MAIN_MEM_PORT_WBUF_EN
   typedef enum logic [2:0] {IDLE, WRITE, READ, RESP, DRAIN} state_t;
`else
   typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;
`endif

   state_t                 state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   in_ready_q;
   logic                   out_ready_q;
   logic [31:0]            out_data_q;
   logic                   sram_en_q;
   logic                   sram_we_q;
   logic [ADDR_WIDTH-1:0]  sram_addr_q;
   logic [31:0]            sram_wdata_q;

   logic [ADDR_WIDTH-1:0]  in_addr_w;
   logic [ADDR_WIDTH-1:0]  out_addr_w;

   assign in_addr_w  = in_addr[ADDR_WIDTH-1:0];
   assign out_addr_w = out_addr[ADDR_WIDTH-1:0];

   // Request address bits above ADDR_WIDTH are deliberately ignored.
   generate
      if (ADDR_WIDTH < 32) begin : g_unused_addr
         logic unused_addr_hi;
         assign unused_addr_hi = ^{in_addr[31:ADDR_WIDTH], out_addr[31:ADDR_WIDTH]};
      end
   endgenerate

`ifdef MAIN_MEM_PORT_WBUF_EN
   logic                   wb_vld_q;
   logic [ADDR_WIDTH-1:0]  wb_addr_q;
   logic [31:0]            wb_data_q;
   logic                   fwd_hit;
   logic                   do_drain;

   assign fwd_hit  = wb_vld_q && (wb_addr_q == out_addr_w);
   // Drain when a store would evict a different address, or when the port is otherwise idle.
   assign do_drain = wb_vld_q && (in_valid ? (wb_addr_q != in_addr_w) : !out_valid);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         in_ready_q   <= 1'b0;
         out_ready_q  <= 1'b0;
         out_data_q   <= '0;
         sram_en_q    <= 1'b0;
         sram_we_q    <= 1'b0;
         sram_addr_q  <= '0;
         sram_wdata_q <= '0;
`ifdef MAIN_MEM_PORT_WBUF_EN
         wb_vld_q     <= 1'b0;
`endif
      end else begin
         in_ready_q  <= 1'b0;
         out_ready_q <= 1'b0;
         sram_en_q   <= 1'b0;
         sram_we_q   <= 1'b0;
         case (state_q)
            IDLE: begin
`ifdef MAIN_MEM_PORT_WBUF_EN
               if (do_drain) begin
                  sram_en_q    <= 1'b1;
                  sram_we_q    <= 1'b1;
                  sram_addr_q  <= wb_addr_q;
                  sram_wdata_q <= wb_data_q;
                  wb_vld_q     <= 1'b0;
                  state_q      <= DRAIN;
               end else if (in_valid) begin
                  wb_vld_q   <= 1'b1;
                  wb_addr_q  <= in_addr_w;
                  wb_data_q  <= in_data;
                  in_ready_q <= 1'b1;
                  state_q    <= WRITE;
               end else if (out_valid && fwd_hit) begin
                  out_data_q  <= wb_data_q;
                  out_ready_q <= 1'b1;
                  state_q     <= RESP;
               end else if (out_valid) begin
                  sram_en_q   <= 1'b1;
                  sram_addr_q <= out_addr_w;
                  cnt_q       <= CNT_W'(READ_LATENCY);
                  state_q     <= READ;
               end
`else
               if (in_valid) begin
                  sram_en_q    <= 1'b1;
                  sram_we_q    <= 1'b1;
                  sram_addr_q  <= in_addr_w;
                  sram_wdata_q <= in_data;
                  in_ready_q   <= 1'b1;
                  state_q      <= WRITE;
               end else if (out_valid) begin
                  sram_en_q   <= 1'b1;
                  sram_addr_q <= out_addr_w;
                  cnt_q       <= CNT_W'(READ_LATENCY);
                  state_q     <= READ;
               end
`endif
            end
            WRITE: state_q <= IDLE;
            READ: begin
               // Counter hits zero in the cycle the SRAM presents the read data.
               if (cnt_q == '0) begin
                  out_data_q  <= sram_rdata;
                  out_ready_q <= 1'b1;
                  state_q     <= RESP;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            RESP: state_q <= IDLE;
`ifdef MAIN_MEM_PORT_WBUF_EN
            DRAIN: state_q <= IDLE;
`endif
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready   = in_ready_q;
   assign out_ready  = out_ready_q;
   assign out_data   = out_data_q;
   assign sram_en    = sram_en_q;
   assign sram_we    = sram_we_q;
   assign sram_addr  = sram_addr_q;
   assign sram_wdata = sram_wdata_q;

endmodule
